// File: rtl/aom_guard_pkg.sv
// rtl/aom_guard_pkg.sv - shared types and constants for the AOM overload guard
// Contents: guard FSM state encoding, fault cause bit indices, fault counter
// width and a saturating increment helper for the trip counter.
package aom_guard_pkg;

    typedef enum logic [1:0] {
        NORMAL   = 2'd0,
        TRIP     = 2'd1,
        WAIT_CLR = 2'd2,
        RECOVER  = 2'd3
    } guard_state_t;

    localparam int CAUSE_CONT  = 0;
    localparam int CAUSE_INTG  = 1;
    localparam int FAULT_CNT_W = 16;

    function automatic logic [FAULT_CNT_W-1:0] sat_inc(input logic [FAULT_CNT_W-1:0] v);
        return (&v) ? v : v + FAULT_CNT_W'(1);
    endfunction

endpackage

// File: rtl/aom_err_filter.sv
// rtl/aom_err_filter.sv - consecutive-cycle debounce for one error flag
// Ports:
//   clk_i     in  system clock
//   rst_n_i   in  asynchronous active-low reset
//   err_i     in  raw error flag
//   flag_o    out filtered flag, high once err_i was high ERR_FILTER_LEN cycles in a row
module aom_err_filter #(
    parameter int ERR_FILTER_LEN = 4
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic err_i,
    output logic flag_o
);

    localparam int CW = $clog2(ERR_FILTER_LEN + 1);
    localparam logic [CW-1:0] LEN = CW'(ERR_FILTER_LEN);

    logic [CW-1:0] r_cnt;

    // Saturating run-length counter; any low sample restarts the run.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt <= '0;
        end else if (!err_i) begin
            r_cnt <= '0;
        end else if (r_cnt != LEN) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign flag_o = (r_cnt == LEN);

endmodule

// File: rtl/aom_overload_guard.sv
// rtl/aom_overload_guard.sv - AOM overload fault latch, safe override and ramped recovery
// Optional build macro: AOM_GUARD_AUTO_CLR_EN (WAIT_CLR self-clears after
// HOLD_CYCLES quiet cycles in addition to the host clear).
// Ports:
//   clk_i, rst_n_i                 clock, asynchronous active-low reset
//   aom_continuous_trig_err_i      raw continuous-trig error
//   aom_integral_trig_err_i        raw integral-trig error
//   guard_en_i                     enables new trips from NORMAL
//   laser_aom_en_i/_voltage_i      upstream AOM enable and requested voltage
//   aom_safe_voltage_i             AOM-closed voltage used while faulted
//   fault_clr_i                    host clear pulse
//   aom_voltage_en_o/aom_voltage_o registered AOM DAC enable and code
//   laser_shutdown_o               forces the laser off while faulted
//   fault_latched_o                high in any state but NORMAL
//   fault_cause_o                  {integral, continuous} captured at trip
//   fault_cnt_o                    saturating trip counter
//   guard_state_o                  current FSM state
module aom_overload_guard
    import aom_guard_pkg::*;
#(
    parameter int VOL_W          = 12,
    parameter int ERR_FILTER_LEN = 4,
    parameter int HOLD_CYCLES    = 100_000_000,
    parameter int RAMP_DIV       = 1000,
    parameter int RAMP_STEP      = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   aom_continuous_trig_err_i,
    input  logic                   aom_integral_trig_err_i,
    input  logic                   guard_en_i,
    input  logic                   laser_aom_en_i,
    input  logic [VOL_W-1:0]       laser_aom_voltage_i,
    input  logic [VOL_W-1:0]       aom_safe_voltage_i,
    input  logic                   fault_clr_i,
    output logic                   aom_voltage_en_o,
    output logic [VOL_W-1:0]       aom_voltage_o,
    output logic                   laser_shutdown_o,
    output logic                   fault_latched_o,
    output logic [1:0]             fault_cause_o,
    output logic [FAULT_CNT_W-1:0] fault_cnt_o,
    output logic [1:0]             guard_state_o
);

    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int DW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(RAMP_DIV - 1);
    localparam logic [VOL_W:0] STEP_X   = (VOL_W + 1)'(RAMP_STEP);

    logic w_cont_flt;
    logic w_intg_flt;
    logic w_any_flt;
    logic w_any_raw;

    guard_state_t     r_state;
    guard_state_t     w_next_state;
    logic [HW-1:0]    r_hold_cnt;
    logic [DW-1:0]    r_div_cnt;
    logic [VOL_W-1:0] r_ramp;
    logic [VOL_W-1:0] w_ramp_step;
    logic [VOL_W-1:0] w_ramp_next;
    logic [VOL_W:0]   w_ramp_x;
    logic [VOL_W:0]   w_tgt_x;

    aom_err_filter #(.ERR_FILTER_LEN(ERR_FILTER_LEN)) u_cont_filter (
        .clk_i  (clk_i),
        .rst_n_i(rst_n_i),
        .err_i  (aom_continuous_trig_err_i),
        .flag_o (w_cont_flt)
    );

    aom_err_filter #(.ERR_FILTER_LEN(ERR_FILTER_LEN)) u_intg_filter (
        .clk_i  (clk_i),
        .rst_n_i(rst_n_i),
        .err_i  (aom_integral_trig_err_i),
        .flag_o (w_intg_flt)
    );

    assign w_any_flt = w_cont_flt | w_intg_flt;
    assign w_any_raw = aom_continuous_trig_err_i | aom_integral_trig_err_i;

    // One ramp step toward the live target, computed one bit wider so it
    // cannot wrap; a remaining distance below RAMP_STEP lands on the target.
    always_comb begin
        w_ramp_x = {1'b0, r_ramp};
        w_tgt_x  = {1'b0, laser_aom_voltage_i};
        if (w_tgt_x > w_ramp_x) begin
            w_ramp_step = ((w_tgt_x - w_ramp_x) > STEP_X) ? VOL_W'(w_ramp_x + STEP_X)
                                                          : laser_aom_voltage_i;
        end else begin
            w_ramp_step = ((w_ramp_x - w_tgt_x) > STEP_X) ? VOL_W'(w_ramp_x - STEP_X)
                                                          : laser_aom_voltage_i;
        end
        w_ramp_next = (r_div_cnt == DIV_LAST) ? w_ramp_step : r_ramp;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            NORMAL: begin
                if (guard_en_i && w_any_flt) w_next_state = TRIP;
            end
            TRIP: begin
                if (r_hold_cnt == HOLD_LAST) w_next_state = WAIT_CLR;
            end
            WAIT_CLR: begin
                // A pending trip (filtered flag) also blocks the clear.
                if (fault_clr_i && !w_any_raw && !w_any_flt) begin
                    w_next_state = RECOVER;
                end
`ifdef AOM_GUARD_AUTO_CLR_EN
                else if (!w_any_raw && (r_hold_cnt == HOLD_LAST)) begin
                    w_next_state = RECOVER;
                end
`endif
            end
            RECOVER: begin
                if (w_any_flt) begin
                    w_next_state = TRIP;
                end else if (r_ramp == laser_aom_voltage_i) begin
                    w_next_state = NORMAL;
                end
            end
            default: w_next_state = NORMAL;
        endcase
    end

    // Outputs are registered from the next state so they change on the same
    // edge as the state register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state          <= NORMAL;
            r_hold_cnt       <= '0;
            r_div_cnt        <= '0;
            r_ramp           <= '0;
            aom_voltage_en_o <= 1'b0;
            aom_voltage_o    <= '0;
            laser_shutdown_o <= 1'b0;
            fault_latched_o  <= 1'b0;
            fault_cause_o    <= '0;
            fault_cnt_o      <= '0;
        end else begin
            r_state         <= w_next_state;
            fault_latched_o <= (w_next_state != NORMAL);

            case (w_next_state)
                NORMAL: begin
                    aom_voltage_o    <= laser_aom_voltage_i;
                    aom_voltage_en_o <= laser_aom_en_i;
                    laser_shutdown_o <= 1'b0;
                end
                TRIP, WAIT_CLR: begin
                    aom_voltage_o    <= aom_safe_voltage_i;
                    aom_voltage_en_o <= 1'b1;
                    laser_shutdown_o <= 1'b1;
                end
                default: begin
                    aom_voltage_o    <= (r_state == RECOVER) ? w_ramp_next : aom_safe_voltage_i;
                    aom_voltage_en_o <= 1'b1;
                    laser_shutdown_o <= 1'b0;
                end
            endcase

            if ((w_next_state == TRIP) && (r_state != TRIP)) begin
                fault_cause_o[CAUSE_CONT] <= w_cont_flt;
                fault_cause_o[CAUSE_INTG] <= w_intg_flt;
                fault_cnt_o               <= sat_inc(fault_cnt_o);
                r_hold_cnt                <= '0;
            end else if (r_state == TRIP) begin
                r_hold_cnt <= (w_next_state == WAIT_CLR) ? '0 : r_hold_cnt + HW'(1);
            end
`ifdef AOM_GUARD_AUTO_CLR_EN
            else if (r_state == WAIT_CLR) begin
                r_hold_cnt <= w_any_raw ? '0 : r_hold_cnt + HW'(1);
            end
`endif

            if ((w_next_state == RECOVER) && (r_state != RECOVER)) begin
                r_ramp    <= aom_safe_voltage_i;
                r_div_cnt <= '0;
            end else if (r_state == RECOVER) begin
                r_ramp    <= w_ramp_next;
                r_div_cnt <= (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + DW'(1);
            end
        end
    end

    assign guard_state_o = r_state;

endmodule
